hazard_fwd_unit: RTL and testbench
==================================

Name: hazard_fwd_unit

Overview:
- Consumer-side companion to the ID/EX pipeline register. It watches the destination and control fields leaving ID/EX (rd, RF_LE, L) and the source registers of the instruction in ID.
- Produces operand-forwarding selects, load-use stall enables for PC and IF/ID, and the `flush` (bubble) request that drives ID/EX.
- Keeps its own shadow copy of the EX→MEM→WB destination pipeline, so no MEM/WB register taps are needed.

Parameters:
- `REG_W`, 5: register-index width.
- `MAX_CONSEC_STALL`, 2: consecutive stall cycles at which `hazard_err` is set.
- `STAT_W`, 32: width of the statistics counters.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `rs1_id`  in  REG_W  ID source register 1
- `rs2_id`  in  REG_W  ID source register 2
- `rs3_id`  in  REG_W  ID third source (store data / RD read)
- `use_rs1_id`  in  1  ID reads rs1
- `use_rs2_id`  in  1  ID reads rs2
- `use_rs3_id`  in  1  ID reads rs3
- `rd_ex`  in  REG_W  destination from ID/EX (RD_out)
- `rf_le_ex`  in  1  register-file write enable from ID/EX (RF_LE_out)
- `l_ex`  in  1  load flag from ID/EX (L_out)
- `fwd_a`  out  2  rs1 operand select: 00 RF, 01 EX, 10 MEM, 11 WB
- `fwd_b`  out  2  rs2 operand select, same encoding
- `fwd_c`  out  2  rs3 operand select, same encoding
- `pc_le`  out  1  PC load enable
- `ifid_le`  out  1  IF/ID load enable
- `idex_flush`  out  1  bubble request to ID/EX `flush`
- `hazard_err`  out  1  sticky protocol-error flag
- `stall_total`  out  STAT_W  stall-cycle count
- `fwd_total`  out  STAT_W  forwarding-cycle count

Behaviour:
- Clock/reset: clock `clk`; reset `reset`, synchronous, active-high.
- Shadow pipeline (registered):
  - Every cycle: `mem_rd <= rd_ex`, `mem_le <= rf_le_ex`, `wb_rd <= mem_rd`, `wb_le <= mem_le`.
  - The shadow never stalls; MEM and WB always advance.
  - Reset clears all shadow registers to 0.
- Forwarding match, per source Sx:
  - A source matches a stage when `use_Sx=1`, `Sx≠0`, the stage's LE=1, and the stage's rd equals Sx.
  - Priority: EX > MEM > WB. No match selects RF (00).
  - Register 0 is never forwarded.
- Load-use hazard:
  - `lu = l_ex & rf_le_ex & (rd_ex≠0)`, and `rd_ex` matches any used source in ID.
  - When `lu=1`: `pc_le=0`, `ifid_le=0`, `idex_flush=1`, and all `fwd_*=00`.
  - The stall lasts one cycle. Next cycle the load sits in the shadow MEM slot, EX holds the bubble (rd=0), and the select becomes 10.
- Outputs are combinational from inputs and shadow state.
- While `reset=1`: `fwd_*=00`, `pc_le=1`, `ifid_le=1`, `idex_flush=0`.
- Consecutive-stall counter:
  - Registered, saturating at `MAX_CONSEC_STALL`.
  - Increments on each `lu` cycle; clears on any cycle with `lu=0`.
  - When it reaches `MAX_CONSEC_STALL`, `hazard_err` is set (sticky); only `reset` clears it.
  - Indicates ID/EX failed to insert a bubble.
- Simultaneous matches: EX non-load with MEM and WB all matching selects 01. A load-use stall overrides every forwarding select.
- Reset mid-stall: shadow, counters and `hazard_err` return to 0 on the same edge.
- Reset values: `hazard_err=0`, `stall_total=0`, `fwd_total=0`.

Optional Feature:
- Macro: `HAZ_STATS_EN`.
- Defined:
  - `stall_total` increments on every `lu` cycle.
  - `fwd_total` increments on every cycle where any `fwd_*≠00`.
  - Both wrap at 2^STAT_W and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Shared package `hazard_pkg`:
  - forwarding encodings `FWD_RF=2'b00`, `FWD_EX=2'b01`, `FWD_MEM=2'b10`, `FWD_WB=2'b11`
  - `REG_ZERO=0`
- One natural sub-module, `fwd_sel`: a purely combinational per-operand priority selector, instantiated three times.
- Shadow pipeline, stall logic and counters live in the top module.

Test Plan:
- Load-use stall:
  - Stimulus: `l_ex=1`, `rf_le_ex=1`, `rd_ex=8`; ID `rs1=8`, `use_rs1=1`.
  - Same cycle: `pc_le=0`, `ifid_le=0`, `idex_flush=1`.
  - Next cycle, with bubble `rd_ex=0`: `fwd_a=10`, no stall.
- EX priority: ALU op in EX with `rd_ex=5`; shadow MEM and WB also hold rd=5; ID `rs2=5` → `fwd_b=01`.
- Register 0: `rd_ex=0`, `rf_le_ex=1`, `use_rs1=1`, `rs1=0` → `fwd_a=00`, no stall.
- Missing bubble:
  - Stimulus: hold the load-use condition for 2 cycles.
  - Response: `hazard_err=1` on the 3rd edge and stays 1.
  - Asserting `reset` for 1 cycle clears it.
- WB forward and `HAZ_STATS_EN` counting:
  - Stimulus: write `rd=12` in EX, then bubbles for 2 cycles; ID `rs3=12`, `use_rs3=1`.
  - Response: `fwd_c=11`.
  - With `HAZ_STATS_EN`: `fwd_total` increments by 1 on that cycle.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared encodings for the hazard / forwarding unit.
//               Operand-select codes and the hard-wired zero register index.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Operand source select codes
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    // Architectural zero register; writes to it are discarded, so never forward
    localparam int REG_ZERO = 0;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/fwd_sel.sv
`default_nettype none
// ============================================================================
// Module      : fwd_sel
// Description : Per-operand forwarding priority selector (EX > MEM > WB > RF).
//               Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] src,
    input  logic             use_src,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_le,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_le,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_le,
    output logic [1:0]       sel
);

    logic w_live;
    logic w_hit_ex;
    logic w_hit_mem;
    logic w_hit_wb;

    // A source is only eligible if it is really read and is not the zero register
    assign w_live    = use_src && (src != REG_W'(REG_ZERO));
    assign w_hit_ex  = w_live && ex_le  && (ex_rd  == src);
    assign w_hit_mem = w_live && mem_le && (mem_rd == src);
    assign w_hit_wb  = w_live && wb_le  && (wb_rd  == src);

    // Youngest producer wins
    always_comb begin
        sel = FWD_RF;
        if (w_hit_ex)
            sel = FWD_EX;
        else if (w_hit_mem)
            sel = FWD_MEM;
        else if (w_hit_wb)
            sel = FWD_WB;
    end

endmodule : fwd_sel
`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_fwd_unit
// Description : Operand forwarding and load-use stall control sitting after
//               the ID/EX register. Tracks EX->MEM->WB destinations in a
//               private shadow pipeline. Optional statistics counters are
//               built when HAZ_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_W            = 5,
    parameter int MAX_CONSEC_STALL = 2,
    parameter int STAT_W           = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  rs1_id,
    input  logic [REG_W-1:0]  rs2_id,
    input  logic [REG_W-1:0]  rs3_id,
    input  logic              use_rs1_id,
    input  logic              use_rs2_id,
    input  logic              use_rs3_id,
    input  logic [REG_W-1:0]  rd_ex,
    input  logic              rf_le_ex,
    input  logic              l_ex,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [1:0]        fwd_c,
    output logic              pc_le,
    output logic              ifid_le,
    output logic              idex_flush,
    output logic              hazard_err,
    output logic [STAT_W-1:0] stall_total,
    output logic [STAT_W-1:0] fwd_total
);

    localparam int                CNT_W   = $clog2(MAX_CONSEC_STALL + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_CONSEC_STALL);

    logic [REG_W-1:0] r_mem_rd;
    logic             r_mem_le;
    logic [REG_W-1:0] r_wb_rd;
    logic             r_wb_le;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_hazard_err;

    logic [1:0]       w_sel_a;
    logic [1:0]       w_sel_b;
    logic [1:0]       w_sel_c;
    logic             w_src_hit;
    logic             w_lu;

    // Shadow of the EX->MEM->WB destination path; never stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_rd <= '0;
            r_mem_le <= 1'b0;
            r_wb_rd  <= '0;
            r_wb_le  <= 1'b0;
        end else begin
            r_mem_rd <= rd_ex;
            r_mem_le <= rf_le_ex;
            r_wb_rd  <= r_mem_rd;
            r_wb_le  <= r_mem_le;
        end
    end

    fwd_sel #(.REG_W(REG_W)) u_fwd_sel_a (
        .src(rs1_id), .use_src(use_rs1_id),
        .ex_rd(rd_ex), .ex_le(rf_le_ex),
        .mem_rd(r_mem_rd), .mem_le(r_mem_le),
        .wb_rd(r_wb_rd), .wb_le(r_wb_le),
        .sel(w_sel_a)
    );

    fwd_sel #(.REG_W(REG_W)) u_fwd_sel_b (
        .src(rs2_id), .use_src(use_rs2_id),
        .ex_rd(rd_ex), .ex_le(rf_le_ex),
        .mem_rd(r_mem_rd), .mem_le(r_mem_le),
        .wb_rd(r_wb_rd), .wb_le(r_wb_le),
        .sel(w_sel_b)
    );

    fwd_sel #(.REG_W(REG_W)) u_fwd_sel_c (
        .src(rs3_id), .use_src(use_rs3_id),
        .ex_rd(rd_ex), .ex_le(rf_le_ex),
        .mem_rd(r_mem_rd), .mem_le(r_mem_le),
        .wb_rd(r_wb_rd), .wb_le(r_wb_le),
        .sel(w_sel_c)
    );

    // Load in EX whose destination is read in ID: data not ready until MEM
    assign w_src_hit = (use_rs1_id && (rs1_id == rd_ex)) ||
                       (use_rs2_id && (rs2_id == rd_ex)) ||
                       (use_rs3_id && (rs3_id == rd_ex));
    assign w_lu      = l_ex && rf_le_ex && (rd_ex != REG_W'(REG_ZERO)) && w_src_hit;

    // Stall/forward outputs; a load-use stall masks every forward select
    always_comb begin
        fwd_a      = FWD_RF;
        fwd_b      = FWD_RF;
        fwd_c      = FWD_RF;
        pc_le      = 1'b1;
        ifid_le    = 1'b1;
        idex_flush = 1'b0;
        if (!reset) begin
            if (w_lu) begin
                pc_le      = 1'b0;
                ifid_le    = 1'b0;
                idex_flush = 1'b1;
            end else begin
                fwd_a = w_sel_a;
                fwd_b = w_sel_b;
                fwd_c = w_sel_c;
            end
        end
    end

    // Back-to-back stalls mean ID/EX did not take the bubble; latch an error
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt  <= '0;
            r_hazard_err <= 1'b0;
        end else begin
            if (!w_lu)
                r_stall_cnt <= '0;
            else if (r_stall_cnt != CNT_MAX)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            r_hazard_err <= r_hazard_err || (r_stall_cnt == CNT_MAX);
        end
    end

    assign hazard_err = r_hazard_err;

`ifdef HAZ_STATS_EN
    logic [STAT_W-1:0] r_stall_total;
    logic [STAT_W-1:0] r_fwd_total;
    logic              w_fwd_any;

    assign w_fwd_any = (fwd_a != FWD_RF) || (fwd_b != FWD_RF) || (fwd_c != FWD_RF);

    // Free-running wrap-around statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_total <= '0;
            r_fwd_total   <= '0;
        end else begin
            if (w_lu)
                r_stall_total <= r_stall_total + STAT_W'(1);
            if (w_fwd_any)
                r_fwd_total <= r_fwd_total + STAT_W'(1);
        end
    end

    assign stall_total = r_stall_total;
    assign fwd_total   = r_fwd_total;
`else
    assign stall_total = '0;
    assign fwd_total   = '0;
`endif

endmodule : hazard_fwd_unit
`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_fwd_unit
// Description : Directed self-checking bench for hazard_fwd_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_fwd_unit;

    localparam int REG_W  = 5;
    localparam int STAT_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [REG_W-1:0]  rs1_id, rs2_id, rs3_id;
    logic              use_rs1_id, use_rs2_id, use_rs3_id;
    logic [REG_W-1:0]  rd_ex;
    logic              rf_le_ex, l_ex;
    logic [1:0]        fwd_a, fwd_b, fwd_c;
    logic              pc_le, ifid_le, idex_flush, hazard_err;
    logic [STAT_W-1:0] stall_total, fwd_total;

    int total = 0;
    int bad   = 0;
    logic [STAT_W-1:0] r_snap;

    hazard_fwd_unit #(.REG_W(REG_W), .MAX_CONSEC_STALL(2), .STAT_W(STAT_W)) dut (
        .clk(clk), .reset(reset),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs3_id(rs3_id),
        .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .use_rs3_id(use_rs3_id),
        .rd_ex(rd_ex), .rf_le_ex(rf_le_ex), .l_ex(l_ex),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c),
        .pc_le(pc_le), .ifid_le(ifid_le), .idex_flush(idex_flush),
        .hazard_err(hazard_err),
        .stall_total(stall_total), .fwd_total(fwd_total)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive the EX-stage fields
    task automatic set_ex(input logic [REG_W-1:0] rd, input logic le, input logic ld);
        rd_ex = rd; rf_le_ex = le; l_ex = ld;
    endtask

    // Drive the ID-stage sources
    task automatic set_id(input logic [REG_W-1:0] s1, input logic u1,
                          input logic [REG_W-1:0] s2, input logic u2,
                          input logic [REG_W-1:0] s3, input logic u3);
        rs1_id = s1; use_rs1_id = u1;
        rs2_id = s2; use_rs2_id = u2;
        rs3_id = s3; use_rs3_id = u3;
    endtask

    // Advance one clock; inputs change 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        set_ex(5'd8, 1'b1, 1'b1);
        set_id(5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        #2;
        // Outputs forced idle during reset even with a hazard presented
        check("rst_pc_le", {31'd0, pc_le}, 32'd1);
        check("rst_ifid_le", {31'd0, ifid_le}, 32'd1);
        check("rst_flush", {31'd0, idex_flush}, 32'd0);
        check("rst_fwd_a", {30'd0, fwd_a}, 32'd0);
        step();
        step();
        check("rst_err", {31'd0, hazard_err}, 32'd0);
        check("rst_stall_total", stall_total, 32'd0);
        check("rst_fwd_total", fwd_total, 32'd0);

        // ---- load-use stall then MEM forward
        reset = 1'b0;
        set_ex(5'd0, 1'b0, 1'b0);
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        set_ex(5'd8, 1'b1, 1'b1);
        set_id(5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        check("lu_pc_le", {31'd0, pc_le}, 32'd0);
        check("lu_ifid_le", {31'd0, ifid_le}, 32'd0);
        check("lu_flush", {31'd0, idex_flush}, 32'd1);
        check("lu_fwd_a", {30'd0, fwd_a}, 32'd0);
        step();
        set_ex(5'd0, 1'b0, 1'b0);
        #1;
        check("post_lu_fwd_a_mem", {30'd0, fwd_a}, 32'd2);
        check("post_lu_pc_le", {31'd0, pc_le}, 32'd1);
        check("post_lu_flush", {31'd0, idex_flush}, 32'd0);
`ifdef HAZ_STATS_EN
        check("stall_total_1", stall_total, 32'd1);
`else
        check("stall_total_tied", stall_total, 32'd0);
`endif
        step();
        check("fwd_a_wb", {30'd0, fwd_a}, 32'd3);
        step();
        check("fwd_a_drained", {30'd0, fwd_a}, 32'd0);
`ifdef HAZ_STATS_EN
        check("fwd_total_2", fwd_total, 32'd2);
`else
        check("fwd_total_tied", fwd_total, 32'd0);
`endif

        // ---- EX priority over MEM and WB
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        set_ex(5'd5, 1'b1, 1'b0);
        step();
        step();
        set_id(5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
        #1;
        check("ex_prio_fwd_b", {30'd0, fwd_b}, 32'd1);
        check("ex_prio_fwd_a", {30'd0, fwd_a}, 32'd1);
        check("ex_prio_no_stall", {31'd0, pc_le}, 32'd1);
        // Same pattern but EX is a load: stall masks all selects
        l_ex = 1'b1;
        #1;
        check("lu_override_fwd_b", {30'd0, fwd_b}, 32'd0);
        check("lu_override_flush", {31'd0, idex_flush}, 32'd1);
        // EX not writing: MEM becomes the youngest producer
        l_ex = 1'b0; rf_le_ex = 1'b0;
        #1;
        check("mem_when_ex_off", {30'd0, fwd_b}, 32'd2);

        // ---- register 0 never forwarded nor stalled on
        set_ex(5'd0, 1'b1, 1'b1);
        set_id(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        check("r0_fwd_a", {30'd0, fwd_a}, 32'd0);
        check("r0_no_stall", {31'd0, pc_le}, 32'd1);

        // ---- WB forward on rs3
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        set_ex(5'd12, 1'b1, 1'b0);
        step();
        set_ex(5'd0, 1'b0, 1'b0);
        step();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1);
        #1;
        check("wb_fwd_c", {30'd0, fwd_c}, 32'd3);
        check("wb_fwd_b_idle", {30'd0, fwd_b}, 32'd0);
        r_snap = fwd_total;
        step();
`ifdef HAZ_STATS_EN
        check("fwd_total_inc", fwd_total, r_snap + 32'd1);
`else
        check("fwd_total_still_0", fwd_total, 32'd0);
`endif

        // ---- missing bubble: load-use held for two cycles
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_ex(5'd8, 1'b1, 1'b1);
        set_id(5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        check("err_after_1", {31'd0, hazard_err}, 32'd0);
        step();
        check("err_after_2", {31'd0, hazard_err}, 32'd0);
        set_ex(5'd0, 1'b0, 1'b0);
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        check("err_after_3", {31'd0, hazard_err}, 32'd1);
        step();
        check("err_sticky", {31'd0, hazard_err}, 32'd1);
`ifdef HAZ_STATS_EN
        check("stall_total_2", stall_total, 32'd2);
`endif
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("err_cleared", {31'd0, hazard_err}, 32'd0);

        // ---- single stall is legal: no error
        set_ex(5'd9, 1'b1, 1'b1);
        set_id(5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0);
        step();
        set_ex(5'd0, 1'b0, 1'b0);
        #1;
        check("single_stall_fwd_b", {30'd0, fwd_b}, 32'd2);
        step();
        step();
        check("single_stall_no_err", {31'd0, hazard_err}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always terminates
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_hazard_fwd_unit
`default_nettype wire
